// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional branch history table is enabled with the IF_BHT_EN macro.
package inst_fetcher_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic JUMP     = 1'b1;
    localparam logic NOT_JUMP = 1'b0;

    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_BR  = 7'b1100011;

    typedef enum logic [1:0] {
        IF_IDLE    = 2'd0,
        IF_BUSY    = 2'd1,
        IF_DISCARD = 2'd2
    } if_state_t;

    function automatic int unsigned iq_ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic logic [ADDR_W-1:0] imm_j(input logic [INST_W-1:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [ADDR_W-1:0] imm_b(input logic [INST_W-1:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetcher_bht.sv
// Branch history table: 2-bit saturating counters, read combinationally by fetch PC,
// updated by committed branches. Only instantiated when IF_BHT_EN is defined.
module if_bht
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] i_rd_pc,
    output logic              o_taken,
    input  logic              i_upd_en,
    input  logic [ADDR_W-1:0] i_upd_pc,
    input  logic              i_upd_taken
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       r_cnt [BHT_ENTRIES];
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [1:0]       w_upd_cur;
    logic             w_unused_pc;

    assign w_rd_idx    = i_rd_pc[IDX_W+1:2];
    assign w_upd_idx   = i_upd_pc[IDX_W+1:2];
    assign w_upd_cur   = r_cnt[w_upd_idx];
    // Read sees the registered array, so a same-cycle update returns the old counter.
    assign o_taken     = r_cnt[w_rd_idx][1];
    assign w_unused_pc = ^{i_rd_pc[ADDR_W-1:IDX_W+2], i_rd_pc[1:0],
                           i_upd_pc[ADDR_W-1:IDX_W+2], i_upd_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                r_cnt[i] <= 2'b01;
            end
        end else if (rdy && i_upd_en) begin
            if (i_upd_taken && (w_upd_cur != 2'b11)) begin
                r_cnt[w_upd_idx] <= w_upd_cur + 2'd1;
            end else if (!i_upd_taken && (w_upd_cur != 2'b00)) begin
                r_cnt[w_upd_idx] <= w_upd_cur - 2'd1;
            end
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: one outstanding memory request, next-PC prediction, instruction queue
// feeding the decoder, ROB flush redirect. Define IF_BHT_EN for BHT branch prediction.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int unsigned IQ_DEPTH    = 16,
    parameter int unsigned BHT_ENTRIES = 256,
    parameter logic [31:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    output logic              oMC_en,
    output logic [ADDR_W-1:0] oMC_addr,
    input  logic              iMC_done,
    input  logic [INST_W-1:0] iMC_inst,
    input  logic              iDEC_stall,
    output logic              oDEC_en,
    output logic [INST_W-1:0] oDEC_inst,
    output logic [ADDR_W-1:0] oDEC_pc,
    output logic              oDEC_pd,
    input  logic              iROB_flush,
    input  logic [ADDR_W-1:0] iROB_pc,
    input  logic              iROB_br_en,
    input  logic [ADDR_W-1:0] iROB_br_pc,
    input  logic              iROB_br_taken
);

    localparam int unsigned    PTR_W   = iq_ptr_w(IQ_DEPTH);
    localparam logic [PTR_W:0] IQ_FULL = (PTR_W+1)'(IQ_DEPTH);

    if_state_t         r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [INST_W-1:0] r_iq_inst [IQ_DEPTH];
    logic [ADDR_W-1:0] r_iq_pc   [IQ_DEPTH];
    logic              r_iq_pd   [IQ_DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W:0]    r_count;

    logic [6:0]        w_opcode;
    logic              w_bht_taken;
    logic              w_pd;
    logic [ADDR_W-1:0] w_npc;
    logic              w_push;
    logic              w_pop;

`ifdef IF_BHT_EN
    if_bht #(
        .BHT_ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .i_rd_pc     (r_pc),
        .o_taken     (w_bht_taken),
        .i_upd_en    (iROB_br_en),
        .i_upd_pc    (iROB_br_pc),
        .i_upd_taken (iROB_br_taken)
    );
`else
    logic w_unused_br;
    assign w_bht_taken = NOT_JUMP;
    assign w_unused_br = ^{iROB_br_en, iROB_br_pc, iROB_br_taken, BHT_ENTRIES[0]};
`endif

    always_comb begin
        w_opcode = iMC_inst[6:0];
        w_pd     = NOT_JUMP;
        w_npc    = r_pc + 32'd4;
        if (w_opcode == OPC_JAL) begin
            w_pd  = JUMP;
            w_npc = r_pc + imm_j(iMC_inst);
        end else if ((w_opcode == OPC_BR) && w_bht_taken) begin
            w_pd  = JUMP;
            w_npc = r_pc + imm_b(iMC_inst);
        end
    end

    assign w_push = (r_state == IF_BUSY) && iMC_done && !iROB_flush;
    assign w_pop  = (r_count != '0) && !iDEC_stall && !iROB_flush;

    always_ff @(posedge clk) begin
        if (rdy && w_push) begin
            r_iq_inst[r_tail] <= iMC_inst;
            r_iq_pc[r_tail]   <= r_pc;
            r_iq_pd[r_tail]   <= w_pd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IF_IDLE;
            r_pc      <= RESET_PC;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            oMC_en    <= 1'b0;
            oMC_addr  <= '0;
            oDEC_en   <= 1'b0;
            oDEC_inst <= '0;
            oDEC_pc   <= '0;
            oDEC_pd   <= 1'b0;
        end else if (rdy) begin
            if (iROB_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                oDEC_en <= 1'b0;
                r_pc    <= iROB_pc;
                // An in-flight request must still be retired; its data is dropped.
                case (r_state)
                    IF_BUSY, IF_DISCARD: begin
                        if (iMC_done) begin
                            oMC_en  <= 1'b0;
                            r_state <= IF_IDLE;
                        end else begin
                            r_state <= IF_DISCARD;
                        end
                    end
                    default: r_state <= IF_IDLE;
                endcase
            end else begin
                case (r_state)
                    IF_IDLE: begin
                        if (r_count != IQ_FULL) begin
                            oMC_en   <= 1'b1;
                            oMC_addr <= r_pc;
                            r_state  <= IF_BUSY;
                        end
                    end
                    IF_BUSY: begin
                        if (iMC_done) begin
                            r_pc    <= w_npc;
                            oMC_en  <= 1'b0;
                            r_state <= IF_IDLE;
                        end
                    end
                    IF_DISCARD: begin
                        if (iMC_done) begin
                            oMC_en  <= 1'b0;
                            r_state <= IF_IDLE;
                        end
                    end
                    default: r_state <= IF_IDLE;
                endcase

                if (w_push) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_pop) begin
                    r_head    <= r_head + 1'b1;
                    oDEC_en   <= 1'b1;
                    oDEC_inst <= r_iq_inst[r_head];
                    oDEC_pc   <= r_iq_pc[r_head];
                    oDEC_pd   <= r_iq_pd[r_head];
                end else begin
                    oDEC_en <= 1'b0;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

endmodule
